// File: rtl/m68k_bus_arbiter.sv
// m68k_bus_arbiter: hands the 68000 bus to an external DMA master.
// BR/BGACK handshake, held off while the local bus sequencer is mid-cycle.
// Every decision is taken on a falling edge of the 7 MHz bus clock, which is
// detected after synchronizing that clock into the PI_CLK domain.
module m68k_bus_arbiter #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic [7:0]  GRANT_TIMEOUT  = 8'd255,
  parameter int unsigned RECLAIM_CYCLES = 2
) (
  input  logic       PI_CLK,
  input  logic       RST,
  input  logic       M68K_CLK,
  input  logic       M68K_BR_n,
  input  logic       M68K_BGACK_n,
  input  logic       CPU_BUSY,
  input  logic       ERR_CLR,
  output logic       M68K_BG_n,
  output logic       CPU_GNT,
  output logic       DMA_ACTIVE,
  output logic       TIMEOUT_ERR,
  output logic [2:0] ARB_STATE
);

  localparam logic [7:0] RECLAIM_LAST = 8'(RECLAIM_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PEND    = 3'd1,
    GRANT   = 3'd2,
    DMA     = 3'd3,
    RECLAIM = 3'd4
  } state_e;

  logic [SYNC_STAGES-1:0] br_sync_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic [2:0]             c7m_q;
  logic                   br;
  logic                   ack;
  logic                   c7m_fall;

  state_e     state_q;
  logic [7:0] cnt_q;
  logic       err_q;

  // Synchronizers for the asynchronous bus-side inputs; idle values on reset.
  always_ff @(posedge PI_CLK) begin
    if (RST) begin
      br_sync_q  <= '1;
      ack_sync_q <= '1;
      c7m_q      <= '0;
    end else begin
      br_sync_q  <= {br_sync_q[SYNC_STAGES-2:0], M68K_BR_n};
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], M68K_BGACK_n};
      c7m_q      <= {c7m_q[1:0], M68K_CLK};
    end
  end

  assign br       = ~br_sync_q[SYNC_STAGES-1];
  assign ack      = ~ack_sync_q[SYNC_STAGES-1];
  assign c7m_fall = c7m_q[2] & ~c7m_q[1];

  // Arbitration FSM, counter and sticky timeout flag; advances only on c7m falls.
  always_ff @(posedge PI_CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // A clear is overridden by a timeout set later in this block.
      if (ERR_CLR) err_q <= 1'b0;
      if (c7m_fall) begin
        case (state_q)
          IDLE: begin
            if (br) begin
              state_q <= PEND;
              cnt_q   <= '0;
            end
          end
          PEND: begin
            if (!br) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (!CPU_BUSY) begin
              state_q <= GRANT;
              cnt_q   <= '0;
            end
          end
          GRANT: begin
            if (ack) begin
              state_q <= DMA;
              cnt_q   <= '0;
            end else if (!br) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == GRANT_TIMEOUT) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              err_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          DMA: begin
            if (!ack) begin
              state_q <= RECLAIM;
              cnt_q   <= '0;
            end
          end
          RECLAIM: begin
            if (cnt_q == RECLAIM_LAST) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  // Outputs are straight decodes of the state register.
  assign ARB_STATE   = state_q;
  assign CPU_GNT     = (state_q == IDLE);
  assign M68K_BG_n   = (state_q != GRANT);
  assign DMA_ACTIVE  = (state_q == DMA);
  assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Bench for m68k_bus_arbiter: vector table, corner-case sequences, random run.
`timescale 1ns/1ps
module tb_m68k_bus_arbiter;

  localparam logic [7:0]  TO = 8'd4;
  localparam int unsigned RC = 2;

  logic       PI_CLK = 1'b0;
  logic       RST = 1'b1;
  logic       M68K_CLK = 1'b0;
  logic       M68K_BR_n = 1'b1;
  logic       M68K_BGACK_n = 1'b1;
  logic       CPU_BUSY = 1'b0;
  logic       ERR_CLR = 1'b0;
  logic       M68K_BG_n;
  logic       CPU_GNT;
  logic       DMA_ACTIVE;
  logic       TIMEOUT_ERR;
  logic [2:0] ARB_STATE;

  int n_chk = 0;
  int n_fail = 0;

  m68k_bus_arbiter #(
    .SYNC_STAGES(2),
    .GRANT_TIMEOUT(TO),
    .RECLAIM_CYCLES(RC)
  ) dut (
    .PI_CLK(PI_CLK),
    .RST(RST),
    .M68K_CLK(M68K_CLK),
    .M68K_BR_n(M68K_BR_n),
    .M68K_BGACK_n(M68K_BGACK_n),
    .CPU_BUSY(CPU_BUSY),
    .ERR_CLR(ERR_CLR),
    .M68K_BG_n(M68K_BG_n),
    .CPU_GNT(CPU_GNT),
    .DMA_ACTIVE(DMA_ACTIVE),
    .TIMEOUT_ERR(TIMEOUT_ERR),
    .ARB_STATE(ARB_STATE)
  );

  always #5 PI_CLK = ~PI_CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct packed {
    logic       br_n;
    logic       bgack_n;
    logic       busy;
    logic [2:0] st;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int err);
    chk({tag, " ARB_STATE"},   int'(ARB_STATE),   st);
    chk({tag, " BG_n"},        int'(M68K_BG_n),   (st == 2) ? 0 : 1);
    chk({tag, " CPU_GNT"},     int'(CPU_GNT),     (st == 0) ? 1 : 0);
    chk({tag, " DMA_ACTIVE"},  int'(DMA_ACTIVE),  (st == 3) ? 1 : 0);
    chk({tag, " TIMEOUT_ERR"}, int'(TIMEOUT_ERR), err);
  endtask

  // One full M68K_CLK period, starting and ending at a PI_CLK falling edge.
  // The falling edge is acted on by the third PI_CLK rise after M68K_CLK drops;
  // clr_at_fall pulses ERR_CLR exactly on that rise, clr_early in the high phase.
  task automatic c7m_period(input bit clr_early, input bit clr_at_fall);
    M68K_CLK = 1'b1;
    ERR_CLR  = clr_early;
    @(negedge PI_CLK);
    ERR_CLR  = 1'b0;
    repeat (3) @(negedge PI_CLK);
    M68K_CLK = 1'b0;
    repeat (2) @(negedge PI_CLK);
    ERR_CLR  = clr_at_fall;
    @(negedge PI_CLK);
    ERR_CLR  = 1'b0;
    @(negedge PI_CLK);
  endtask

  task automatic step(input logic br_n, input logic bgack_n, input logic busy);
    M68K_BR_n    = br_n;
    M68K_BGACK_n = bgack_n;
    CPU_BUSY     = busy;
    c7m_period(1'b0, 1'b0);
  endtask

  // Reference model: owner of the bus tracked per c7m fall, with a count of
  // falls already spent in the current phase.
  int  m_st;
  int  m_falls;
  bit  m_err;

  function automatic void model_fall(input bit br, input bit ack, input bit busy);
    int nxt = m_st;
    case (m_st)
      0: if (br) nxt = 1;
      1: if (!br) nxt = 0; else if (!busy) nxt = 2;
      2: begin
        if (ack) nxt = 3;
        else if (!br) nxt = 0;
        else if (m_falls == int'(TO)) begin nxt = 0; m_err = 1'b1; end
      end
      3: if (!ack) nxt = 4;
      4: if (m_falls + 1 == int'(RC)) nxt = 0;
      default: nxt = 0;
    endcase
    if (nxt != m_st) m_falls = 0;
    else if (m_st == 2 || m_st == 4) m_falls++;
    m_st = nxt;
  endfunction

  initial begin
    // Reset
    repeat (3) @(negedge PI_CLK);
    chk_all("reset", 0, 0);
    RST = 1'b0;
    @(negedge PI_CLK);

    // Vector table: br_n, bgack_n, busy -> state after the fall, sticky error
    vecs.push_back(vec_t'{1'b1, 1'b1, 1'b0, 3'd0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 3'd1, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 3'd2, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 3'd3, 1'b0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 3'd3, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 3'd4, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 3'd4, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 3'd0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 3'd1, 1'b0});
    for (int i = 0; i < 5; i++) vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 3'd1, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 3'd2, 1'b0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 1'b0, 3'd0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 3'd1, 1'b0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 1'b0, 3'd0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 3'd1, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 3'd2, 1'b0});
    for (int i = 0; i < 4; i++) vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 3'd2, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 3'd0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 3'd1, 1'b1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 3'd2, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 3'd3, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b1, 1'b0, 3'd4, 1'b1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 3'd4, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b1, 1'b0, 3'd0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 3'd1, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b1, 1'b0, 3'd0, 1'b1});

    foreach (vecs[i]) begin
      step(vecs[i].br_n, vecs[i].bgack_n, vecs[i].busy);
      chk_all($sformatf("vec%0d", i), int'(vecs[i].st), int'(vecs[i].err));
    end

    // ERR_CLR on its own clears the sticky flag
    M68K_BR_n = 1'b1;
    c7m_period(1'b1, 1'b0);
    chk_all("err_clr", 0, 0);

    // Timeout with ERR_CLR on the same edge: set wins
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    chk_all("to_pre", 2, 0);
    c7m_period(1'b0, 1'b1);
    chk_all("to_set_vs_clr", 0, 1);

    // Reset in the middle of DMA
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_all("dma_pre_rst", 3, 1);
    RST = 1'b1;
    @(posedge PI_CLK);
    #1;
    chk_all("rst_in_dma", 0, 0);
    M68K_BR_n    = 1'b1;
    M68K_BGACK_n = 1'b1;
    @(negedge PI_CLK);
    @(negedge PI_CLK);
    RST = 1'b0;
    @(negedge PI_CLK);

    // Randomized run against the model
    m_st = 0; m_falls = 0; m_err = 1'b0;
    for (int i = 0; i < 200; i++) begin
      bit br, ack, busy, clr;
      br   = ($urandom_range(0, 9) < 7);
      ack  = ($urandom_range(0, 9) < 3);
      busy = ($urandom_range(0, 9) < 3);
      clr  = ($urandom_range(0, 19) == 0);
      M68K_BR_n    = ~br;
      M68K_BGACK_n = ~ack;
      CPU_BUSY     = busy;
      c7m_period(clr, 1'b0);
      if (clr) m_err = 1'b0;
      model_fall(br, ack, busy);
      chk_all($sformatf("rnd%0d", i), m_st, int'(m_err));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/m68k_bus_arbiter.md
M68K_BUS_ARBITER -- requirements
Module: m68k_bus_arbiter

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for M68K_BR_n, M68K_BGACK_n and M68K_CLK; legal range 2..4.
REQ-002 Parameter GRANT_TIMEOUT, default 8'd255: number of c7m falls in GRANT without BGACK before the grant is abandoned.
REQ-003 Parameter RECLAIM_CYCLES, default 2: number of c7m falls held in RECLAIM after DMA release; legal range 1..15.
REQ-004 The clock is PI_CLK (200 MHz, single clock domain) and the reset is RST; reset is synchronous and active-high.
REQ-005 Ports, listed as name / direction / width / meaning:
- PI_CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- M68K_CLK  in  1  asynchronous 7 MHz bus clock.
- M68K_BR_n  in  1  asynchronous bus request.
- M68K_BGACK_n  in  1  asynchronous bus-grant acknowledge.
- CPU_BUSY  in  1  bus-cycle sequencer is mid-cycle (state not idle).
- ERR_CLR  in  1  one-PI_CLK pulse that clears TIMEOUT_ERR.
- M68K_BG_n  out  1  bus grant to the external master.
- CPU_GNT  out  1  sequencer may start a new cycle.
- DMA_ACTIVE  out  1  external master owns the bus.
- TIMEOUT_ERR  out  1  sticky grant-timeout flag.
- ARB_STATE  out  3  current state encoding.

Function
REQ-006 M68K_BR_n and M68K_BGACK_n SHALL each pass through SYNC_STAGES flops; br = !synced BR_n and ack = !synced BGACK_n.
REQ-007 M68K_CLK SHALL pass through a 3-flop shift register; c7m_fall is a one-PI_CLK pulse when stage[2]=1 and stage[1]=0.
REQ-008 All state transitions and counter updates SHALL occur only on PI_CLK edges where c7m_fall=1; except for reset, state is held on all other cycles.
REQ-009 State encodings SHALL be IDLE=0, PEND=1, GRANT=2, DMA=3, RECLAIM=4; ARB_STATE equals the state register.
REQ-010 Outputs SHALL be decoded from registered state only, with no combinational path from any input:
- CPU_GNT = (IDLE).
- M68K_BG_n = !(GRANT).
- DMA_ACTIVE = (DMA).
REQ-011 IDLE transitions:
- br=1 -> PEND.
- otherwise -> stay in IDLE.
REQ-012 PEND transitions:
- br=0 -> IDLE (request withdrawn).
- br=1 and CPU_BUSY=0 -> GRANT, with the counter cleared.
- br=1 and CPU_BUSY=1 -> stay in PEND; an in-flight CPU cycle is never pre-empted.
REQ-013 GRANT transitions, in priority order:
- ack=1 -> DMA.
- br=0 -> IDLE.
- counter==GRANT_TIMEOUT -> IDLE, with TIMEOUT_ERR set.
- otherwise -> counter+1.
REQ-014 DMA transitions:
- ack=0 -> RECLAIM, with the counter cleared.
- otherwise -> stay in DMA; there is no timeout in DMA.
REQ-015 RECLAIM transitions:
- counter==RECLAIM_CYCLES-1 -> IDLE.
- otherwise -> counter+1.
- br is ignored in RECLAIM.
REQ-016 The counter SHALL be 8 bits unsigned, cleared on every state entry, and SHALL never wrap; GRANT exits at GRANT_TIMEOUT.
REQ-017 Simultaneous events SHALL resolve as follows:
- In IDLE, a CPU_BUSY rise and br on the same fall: move to PEND; CPU_GNT drops on the next PI_CLK and the already-started cycle completes.
- In GRANT, ack and br=0 together: DMA wins.
REQ-018 TIMEOUT_ERR SHALL be set in the PI_CLK cycle of the timeout transition and cleared by ERR_CLR; if both occur in the same cycle, set wins.
REQ-019 Minimum latency from the first c7m_fall with br=1 (and CPU_BUSY=0) to M68K_BG_n low SHALL be 2 c7m falls plus 1 PI_CLK.

Reset
REQ-020 When RST=1 at a PI_CLK edge, all of the following SHALL hold on the next cycle, regardless of current state, including mid-GRANT or mid-DMA:
- state=IDLE, counter=0, TIMEOUT_ERR=0.
- M68K_BG_n=1, CPU_GNT=1, DMA_ACTIVE=0, ARB_STATE=3'd0.
REQ-021 On reset, synchronizer flops SHALL load the idle values: BR_n and BGACK_n stages load 1, and the M68K_CLK stages load 0.
REQ-022 RST SHALL take priority over c7m_fall and ERR_CLR.

Verification
REQ-023 Basic grant: CPU_BUSY=0, BR_n low -> ARB_STATE 0→1→2 on consecutive c7m falls; BG_n=0 and CPU_GNT=0 in GRANT.
REQ-024 Non-pre-emption: BR_n low while CPU_BUSY=1 for 5 c7m falls -> ARB_STATE stays 1 and BG_n=1; after CPU_BUSY=0, GRANT on the next fall.
REQ-025 DMA handover: in GRANT, assert BGACK_n low -> DMA (BG_n=1, DMA_ACTIVE=1). Then release BGACK_n with BR_n still low -> RECLAIM for exactly 2 falls, then IDLE, then PEND.
REQ-026 Timeout: GRANT_TIMEOUT=8'd4, BR_n held low, BGACK_n high -> IDLE after the 5th fall in GRANT with TIMEOUT_ERR=1. ERR_CLR in the same cycle as the set -> TIMEOUT_ERR stays 1.
REQ-027 Withdraw: BR_n released in PEND or GRANT -> IDLE on the next fall with TIMEOUT_ERR=0. RST asserted while in DMA -> next PI_CLK shows ARB_STATE=0, CPU_GNT=1, BG_n=1.
